// File: rtl/vga_scaled_addr_gen.sv
// Scaled-image address generator for the VGA display path.
// It follows the HSYNC/VSYNC counters. Each memory pixel is held for
// CLK_PER_PIX clocks and repeated H_SCALE times along a line. Each memory
// row is repeated V_SCALE times down the frame. The outputs are a
// registered frame-buffer read address and a valid flag for the RGB stage.
module vga_scaled_addr_gen #(
  parameter int CLK_PER_PIX = 4,
  parameter int H_SCALE     = 5,
  parameter int V_SCALE     = 5,
  parameter int SRC_W       = 128,
  parameter int SRC_H       = 96,
  parameter int H_ACT_START = 575,
  parameter int V_ACT_START = 30,
  parameter int ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       H_count,
  input  logic [11:0]       V_count,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  output logic [7:0]        col,
  output logic [6:0]        row,
  output logic              frame_done
);

  // Clocks spent on one memory pixel along a line.
  localparam int H_REP  = CLK_PER_PIX * H_SCALE;
  // Sub-counter widths. They are kept at least one bit wide so that unit
  // scale factors still elaborate.
  localparam int HSUB_W = (H_REP > 1)   ? $clog2(H_REP)   : 1;
  localparam int VSUB_W = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

  localparam logic [HSUB_W-1:0] HSUB_LAST  = HSUB_W'(H_REP - 1);
  localparam logic [VSUB_W-1:0] VSUB_LAST  = VSUB_W'(V_SCALE - 1);
  localparam logic [7:0]        COL_LAST   = 8'(SRC_W - 1);
  localparam logic [6:0]        ROW_LAST   = 7'(SRC_H - 1);
  localparam logic [11:0]       H_START    = 12'(H_ACT_START);
  localparam logic [11:0]       V_START    = 12'(V_ACT_START);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SRC_W);

  // Horizontal state.
  logic [HSUB_W-1:0] hsub;
  logic              h_act;

  // Vertical state. row_base tracks row*SRC_W by accumulation, so the
  // address path needs no multiplier.
  logic [VSUB_W-1:0] vsub;
  logic              v_act;
  logic [ADDR_W-1:0] row_base;

  // Event decode shared by the counters.
  logic start_ev;     // sampled H_count sits one clock before the active span
  logic frame_start;  // start event on the first active line
  logic hsub_wrap;    // last clock of the current memory pixel
  logic span_end;     // last clock of the last memory pixel on the line
  logic v_step;       // line finished inside an active frame
  logic vsub_wrap;    // last repeat of the current memory row
  logic frame_end;    // last repeat of the last memory row

  assign start_ev    = (H_count == H_START);
  assign frame_start = start_ev && (V_count == V_START);
  assign hsub_wrap   = h_act && (hsub == HSUB_LAST);
  assign span_end    = hsub_wrap && (col == COL_LAST);
  // A start event takes over the edge completely. A span cut short by a
  // misplaced sync pulse therefore does not advance the vertical position.
  assign v_step      = span_end && v_act && !start_ev;
  assign vsub_wrap   = v_step && (vsub == VSUB_LAST);
  assign frame_end   = vsub_wrap && (row == ROW_LAST);

  // Horizontal sequencing: clocks within a pixel, then pixels within the span.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsub  <= '0;
      col   <= '0;
      h_act <= 1'b0;
    end else if (start_ev) begin
      hsub  <= '0;
      col   <= '0;
      h_act <= 1'b1;
    end else if (h_act) begin
      if (hsub_wrap) begin
        hsub <= '0;
        if (col == COL_LAST) begin
          col   <= '0;
          h_act <= 1'b0;
        end else begin
          col <= col + 8'd1;
        end
      end else begin
        hsub <= hsub + 1'b1;
      end
    end
  end

  // Vertical sequencing: repeats of a row, then rows of the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vsub     <= '0;
      row      <= '0;
      row_base <= '0;
      v_act    <= 1'b0;
    end else if (frame_start) begin
      vsub     <= '0;
      row      <= '0;
      row_base <= '0;
      v_act    <= 1'b1;
    end else if (v_step) begin
      if (vsub == VSUB_LAST) begin
        vsub <= '0;
        if (row == ROW_LAST) begin
          row      <= '0;
          row_base <= '0;
          v_act    <= 1'b0;
        end else begin
          row      <= row + 7'd1;
          row_base <= row_base + ROW_STRIDE;
        end
      end else begin
        vsub <= vsub + 1'b1;
      end
    end
  end

  // Registered address, valid flag and end-of-frame pulse. These lag
  // col and row by one clock. The address is forced to 0 outside the image.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_addr   <= '0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= h_act && v_act;
      pix_addr   <= (h_act && v_act) ? (row_base + ADDR_W'(col)) : '0;
      frame_done <= frame_end;
    end
  end

endmodule
